// File: rtl/uart_pkg.sv
// Shared UART encodings, FSM state constants and config record (TX and RX engines).
// UART_RX_MAJORITY_EN selects 3-sample majority voting in the receiver.
package uart_pkg;

    localparam int unsigned UART_CLK_DIV_MIN = 4;

    localparam logic [1:0] DATA_5 = 2'b00;
    localparam logic [1:0] DATA_6 = 2'b01;
    localparam logic [1:0] DATA_7 = 2'b10;
    localparam logic [1:0] DATA_8 = 2'b11;

    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

    localparam logic [1:0] CHK_EVEN  = 2'b00;
    localparam logic [1:0] CHK_ODD   = 2'b01;
    localparam logic [1:0] CHK_MARK  = 2'b10;
    localparam logic [1:0] CHK_SPACE = 2'b11;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    // The vote needs the centre+1 sample, so decisions land one cycle later.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [31:0] VOTE_LAG = 32'd1;
`else
    localparam logic [31:0] VOTE_LAG = 32'd0;
`endif

    typedef struct packed {
        logic [31:0] div;
        logic        check_en;
        logic [1:0]  check_type;
        logic [1:0]  data_bit;
        logic [1:0]  stop_bit;
    } uart_cfg_t;

    // Expected parity bit; unused upper data bits are zero so they do not disturb it.
    function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] t);
        case (t)
            CHK_EVEN: return ^d;
            CHK_ODD:  return ~^d;
            CHK_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Synchronizer for the asynchronous rx line plus the bit-value sampler.
// With UART_RX_MAJORITY_EN the sampled bit is a 2-of-3 vote over the last three synced values.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic uart_rx,
    output logic line,
    output logic bit_val
);
    localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [N-1:0] chain;

    // Metastability chain; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '1;
        else        chain <= {chain[N-2:0], uart_rx};
    end

    assign line = chain[N-1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Two previous synced samples for the vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= '1;
        else        hist <= {hist[0], line};
    end

    assign bit_val = (line & hist[0]) | (line & hist[1]) | (hist[0] & hist[1]);
`else
    assign bit_val = line;
`endif

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: mid-bit sampling, 5-8 data bits LSB first, optional parity, 1/1.5/2 stops,
// valid/ready delivery with parity/frame/overrun flags. Optional UART_RX_MAJORITY_EN voting.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned CLK_DIV_MIN = UART_CLK_DIV_MIN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] clk_div,
    input  logic        check_en,
    input  logic [1:0]  check_type,
    input  logic [1:0]  data_bit,
    input  logic [1:0]  stop_bit,
    input  logic        uart_rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_parity_err,
    output logic        rx_frame_err,
    output logic        rx_overrun,
    output logic        rx_busy,
    output logic [15:0] rx_byte_count
);
    localparam logic [31:0] DIV_MIN = 32'(CLK_DIV_MIN);

    logic        line, bit_val, line_prev;
    logic [2:0]  state;
    logic [31:0] timer, div_in;
    uart_cfg_t   cfg_r;
    logic [2:0]  bit_cnt, last_idx;
    logic [7:0]  shreg;
    logic        perr_r, ferr_r, second_r;
    logic        tick, last_stop, ferr_now, frame_done;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart_rx (uart_rx),
        .line    (line),
        .bit_val (bit_val)
    );

    assign div_in  = (clk_div < DIV_MIN) ? DIV_MIN : clk_div;
    assign rx_busy = (state != ST_IDLE);

    // Per-state decode: timer expiry, last data index, final stop sample.
    always_comb begin
        tick       = (timer == 32'd0);
        last_idx   = 3'd4 + {1'b0, cfg_r.data_bit};
        last_stop  = second_r | ~cfg_r.stop_bit[1];
        ferr_now   = ferr_r | ~bit_val;
        frame_done = (state == ST_STOP) && tick && last_stop;
    end

    // Frame FSM with bit-centre down-counter; config is frozen at start-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            cfg_r     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            second_r  <= 1'b0;
            line_prev <= 1'b1;
        end else begin
            line_prev <= line;
            case (state)
                ST_IDLE: if (line_prev && !line) begin
                    state <= ST_START;
                    timer <= (div_in >> 1) - 32'd1 + VOTE_LAG;
                    cfg_r <= '{div: div_in, check_en: check_en, check_type: check_type,
                               data_bit: data_bit, stop_bit: stop_bit};
                end
                ST_START: if (!tick) timer <= timer - 32'd1;
                    else if (bit_val) state <= ST_IDLE;
                    else begin
                        state   <= ST_DATA;
                        timer   <= cfg_r.div - 32'd1;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                ST_DATA: if (!tick) timer <= timer - 32'd1;
                    else begin
                        shreg[bit_cnt] <= bit_val;
                        timer          <= cfg_r.div - 32'd1;
                        if (bit_cnt == last_idx) begin
                            bit_cnt  <= '0;
                            perr_r   <= 1'b0;
                            ferr_r   <= 1'b0;
                            second_r <= 1'b0;
                            state    <= cfg_r.check_en ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                ST_PARITY: if (!tick) timer <= timer - 32'd1;
                    else begin
                        perr_r <= (bit_val != parity_bit(shreg, cfg_r.check_type));
                        timer  <= cfg_r.div - 32'd1;
                        state  <= ST_STOP;
                    end
                ST_STOP: if (!tick) timer <= timer - 32'd1;
                    else if (!last_stop) begin
                        ferr_r   <= ~bit_val;
                        second_r <= 1'b1;
                        timer    <= cfg_r.div - 32'd1;
                    end else begin
                        state <= ferr_now ? ST_WAIT_IDLE : ST_IDLE;
                    end
                ST_WAIT_IDLE: if (line) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Delivery register: load on frame completion unless an unaccepted byte is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_byte_count <= '0;
        end else begin
            rx_overrun <= 1'b0;
            if (frame_done && (!rx_valid || rx_ready)) begin
                rx_data       <= shreg;
                rx_parity_err <= perr_r;
                rx_frame_err  <= ferr_now;
                rx_valid      <= 1'b1;
                rx_byte_count <= rx_byte_count + 16'd1;
            end else begin
                if (frame_done)           rx_overrun <= 1'b1;
                if (rx_valid && rx_ready) rx_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed + randomized bench for uart_rx_engine; a serializer task stands in for the TX engine.
module tb_uart_rx_engine;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] clk_div = 32'd868;
    logic        check_en = 1'b0;
    logic [1:0]  check_type = 2'b00, data_bit = 2'b11, stop_bit = 2'b00;
    logic        uart_rx = 1'b1, rx_ready = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy;
    logic [15:0] rx_byte_count;

    uart_rx_engine dut (
        .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .check_en(check_en),
        .check_type(check_type), .data_bit(data_bit), .stop_bit(stop_bit),
        .uart_rx(uart_rx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .rx_overrun(rx_overrun), .rx_busy(rx_busy), .rx_byte_count(rx_byte_count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] d; logic pe; logic fe; int unsigned t; } cap_t;
    cap_t cap_q[$];
    int   ovr_cnt = 0;
    int unsigned rise_t = 0;
    logic valid_d = 1'b0;

    // Records every accepted byte and counts overrun pulses.
    always @(negedge clk) begin
        cap_t c;
        if (rx_valid && !valid_d) rise_t = cyc;
        if (rx_valid && rx_ready) begin
            c.d = rx_data; c.pe = rx_parity_err; c.fe = rx_frame_err; c.t = rise_t;
            cap_q.push_back(c);
        end
        if (rx_overrun) ovr_cnt++;
        valid_d = rx_valid;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference parity: number of ones decides even/odd; mark/space are constants.
    function automatic bit ref_par(input logic [7:0] d, input logic [1:0] t);
        int ones = $countones(d);
        case (t)
            2'b00:   return (ones % 2) == 1;
            2'b01:   return (ones % 2) == 0;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Serializes one frame at div cycles per bit; optional line-low hold after the stops.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                              input bit par_v, input bit s1, input bit s2,
                              input logic [1:0] sb, input int unsigned div,
                              input int unsigned hold_low, output int unsigned stop_t);
        uart_rx = 1'b0; tick(div);
        for (int i = 0; i < nbits; i++) begin uart_rx = d[i]; tick(div); end
        if (par_en) begin uart_rx = par_v; tick(div); end
        uart_rx = s1; stop_t = cyc; tick(div);
        if (sb == 2'b01)  begin uart_rx = 1'b1; tick(div / 2); end
        else if (sb[1])   begin uart_rx = s2;   tick(div); end
        if (hold_low != 0) begin uart_rx = 1'b0; tick(hold_low * div); end
        uart_rx = 1'b1; tick(2 * div);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] d, input bit pe,
                               input bit fe, output int unsigned t);
        cap_t c;
        int unsigned n = 0;
        t = 0;
        while (cap_q.size() == 0 && n < 4000) begin tick(1); n++; end
        chk({tag, ".seen"}, 32'(cap_q.size() != 0), 32'd1);
        if (cap_q.size() != 0) begin
            c = cap_q.pop_front();
            t = c.t;
            chk({tag, ".data"}, 32'(c.d), 32'(d));
            chk({tag, ".perr"}, 32'(c.pe), 32'(pe));
            chk({tag, ".ferr"}, 32'(c.fe), 32'(fe));
        end
    endtask

    initial begin
        int unsigned st, rt, exp_cnt, ovr0, div, eff, nb;
        logic [7:0] d, mask;
        bit pv, s1, s2, pe, fe;

        exp_cnt = 0;
        tick(3);
        chk("reset.outputs", {3'b0, rx_data, rx_valid, rx_parity_err, rx_frame_err,
                              rx_overrun, rx_busy, rx_byte_count}, 32'd0);
        rst_n = 1'b1; tick(5);

        // 1) 8N1 0x55 at the full baud divider, with delivery latency window
        clk_div = 32'd868;
        send_frame(8'h55, 8, 0, 0, 1, 1, 2'b00, 868, 0, st);
        expect_byte("t1", 8'h55, 0, 0, rt); exp_cnt++;
        chk("t1.latency_ok", 32'((rt - st) >= 434 && (rt - st) <= 440), 32'd1);
        chk("t1.count", 32'(rx_byte_count), exp_cnt);
        chk("t1.valid_clear", {30'd0, rx_valid, rx_busy}, 32'd0);

        // 2) even parity, parity bit forced wrong
        clk_div = 32'd32; check_en = 1'b1; check_type = 2'b00;
        pv = 1'b1;
        send_frame(8'hAA, 8, 1, pv, 1, 1, 2'b00, 32, 0, st);
        expect_byte("t2", 8'hAA, pv != ref_par(8'hAA, 2'b00), 0, rt); exp_cnt++;
        chk("t2.count", 32'(rx_byte_count), exp_cnt);

        // 3) bad stop then 20 bit-times of break; nothing more until line idles, then recovers
        check_en = 1'b0;
        send_frame(8'hF0, 8, 0, 0, 0, 1, 2'b00, 32, 20, st);
        expect_byte("t3", 8'hF0, 0, 1, rt); exp_cnt++;
        chk("t3.no_extra", 32'(cap_q.size()), 32'd0);
        chk("t3.count", 32'(rx_byte_count), exp_cnt);
        send_frame(8'h3C, 8, 0, 0, 1, 1, 2'b00, 32, 0, st);
        expect_byte("t3b", 8'h3C, 0, 0, rt); exp_cnt++;

        // 4) 100-cycle glitch on an idle line
        clk_div = 32'd868;
        uart_rx = 1'b0; tick(50);
        chk("t4.busy_during", 32'(rx_busy), 32'd1);
        tick(50); uart_rx = 1'b1; tick(868);
        chk("t4.no_byte", 32'(cap_q.size()), 32'd0);
        chk("t4.busy_after", 32'(rx_busy), 32'd0);
        chk("t4.count", 32'(rx_byte_count), exp_cnt);

        // 5) consumer stalled: second byte dropped with one overrun pulse
        clk_div = 32'd32; rx_ready = 1'b0; ovr0 = ovr_cnt;
        send_frame(8'h12, 8, 0, 0, 1, 1, 2'b00, 32, 0, st);
        send_frame(8'h34, 8, 0, 0, 1, 1, 2'b00, 32, 0, st);
        exp_cnt++;
        chk("t5.valid_held", 32'(rx_valid), 32'd1);
        chk("t5.data_kept", 32'(rx_data), 32'h12);
        chk("t5.overruns", 32'(ovr_cnt - ovr0), 32'd1);
        chk("t5.count", 32'(rx_byte_count), exp_cnt);
        rx_ready = 1'b1;
        expect_byte("t5", 8'h12, 0, 0, rt);
        tick(2);
        chk("t5.valid_clear", 32'(rx_valid), 32'd0);

        // 6) 5 data bits, 2 stops; then reset in mid-DATA and recover
        data_bit = 2'b00; stop_bit = 2'b10;
        send_frame(8'h1F, 5, 0, 0, 1, 1, 2'b10, 32, 0, st);
        expect_byte("t6", 8'h1F, 0, 0, rt); exp_cnt++;
        uart_rx = 1'b0; tick(32);
        uart_rx = 1'b1; tick(64);
        rst_n = 1'b0; tick(1);
        chk("t6.reset_outputs", {3'b0, rx_data, rx_valid, rx_parity_err, rx_frame_err,
                                 rx_overrun, rx_busy, rx_byte_count}, 32'd0);
        tick(3); rst_n = 1'b1; tick(64);
        exp_cnt = 0;
        send_frame(8'h0A, 5, 0, 0, 1, 1, 2'b10, 32, 0, st);
        expect_byte("t6b", 8'h0A, 0, 0, rt); exp_cnt++;
        chk("t6b.count", 32'(rx_byte_count), exp_cnt);

        // Randomized frames against the reference model (includes clamped tiny dividers)
        for (int k = 0; k < 40; k++) begin
            div = $urandom_range(1, 24);
            eff = (div < 4) ? 4 : div;
            clk_div = div;
            data_bit = 2'($urandom_range(0, 3));
            stop_bit = 2'($urandom_range(0, 3));
            check_en = 1'($urandom_range(0, 1));
            check_type = 2'($urandom_range(0, 3));
            nb = 5 + data_bit;
            mask = 8'hFF >> (8 - nb);
            d = 8'($urandom) & mask;
            pv = ref_par(d, check_type) ^ ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 5) != 0);
            s2 = ($urandom_range(0, 5) != 0);
            pe = check_en && (pv != ref_par(d, check_type));
            fe = !s1 || (stop_bit[1] && !s2);
            send_frame(d, nb, check_en, pv, s1, s2, stop_bit, eff, 0, st);
            expect_byte($sformatf("rnd%0d", k), d, pe, fe, rt); exp_cnt++;
            chk($sformatf("rnd%0d.count", k), 32'(rx_byte_count), exp_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
